// File: rtl/fwd_hazard_unit.sv
// EX-stage forwarding select generator and load-use stall detector.
// Keeps its own ID/EX, EX/MEM and MEM/WB copies of destination and write-enable info.
module fwd_hazard_unit #(
   parameter int REGW      = 5,
   parameter int NREG_ZERO = 0
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            id_valid,
   input  logic [REGW-1:0] id_rs,
   input  logic [REGW-1:0] id_rt,
   input  logic [REGW-1:0] id_dest,
   input  logic            id_regwrite,
   input  logic            id_memread,
   input  logic            flush,
   output logic [1:0]      fwd_a,
   output logic [1:0]      fwd_b,
   output logic            stall
);

   localparam logic [REGW-1:0] ZERO_IDX = REGW'(NREG_ZERO);

   logic [REGW-1:0] ex_rs_r;
   logic [REGW-1:0] ex_rt_r;
   logic [REGW-1:0] ex_dest_r;
   logic            ex_regwrite_r;
   logic            ex_memread_r;
   logic [REGW-1:0] mem_dest_r;
   logic            mem_regwrite_r;
   logic [REGW-1:0] wb_dest_r;
   logic            wb_regwrite_r;

   logic [1:0]      fwd_a_s;
   logic [1:0]      fwd_b_s;
   logic            stall_s;
   logic            idex_load_s;

   // EX/MEM is checked first so the newest in-flight value wins.
   function automatic logic [1:0] fwd_sel(
      input logic [REGW-1:0] src,
      input logic [REGW-1:0] mem_dest,
      input logic            mem_rw,
      input logic [REGW-1:0] wb_dest,
      input logic            wb_rw
   );
      logic [1:0] sel;
      if (mem_rw && (mem_dest != ZERO_IDX) && (mem_dest == src)) begin
         sel = 2'b10;
      end else if (wb_rw && (wb_dest != ZERO_IDX) && (wb_dest == src)) begin
         sel = 2'b01;
      end else begin
         sel = 2'b00;
      end
      return sel;
   endfunction

   // Mux selects and load-use detection, all same-cycle from the shadow registers.
   always_comb begin
      fwd_a_s     = fwd_sel(ex_rs_r, mem_dest_r, mem_regwrite_r, wb_dest_r, wb_regwrite_r);
      fwd_b_s     = fwd_sel(ex_rt_r, mem_dest_r, mem_regwrite_r, wb_dest_r, wb_regwrite_r);
      stall_s     = ex_memread_r && (ex_dest_r != ZERO_IDX) && id_valid &&
                    ((ex_dest_r == id_rs) || (ex_dest_r == id_rt));
      idex_load_s = id_valid && !stall_s && !flush;
   end

   assign fwd_a = fwd_a_s;
   assign fwd_b = fwd_b_s;
   assign stall = stall_s;

   // ID/EX shadow: take the ID instruction or insert a bubble on stall, flush or invalid.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ex_rs_r       <= '0;
         ex_rt_r       <= '0;
         ex_dest_r     <= '0;
         ex_regwrite_r <= 1'b0;
         ex_memread_r  <= 1'b0;
      end else if (idex_load_s) begin
         ex_rs_r       <= id_rs;
         ex_rt_r       <= id_rt;
         ex_dest_r     <= id_dest;
         ex_regwrite_r <= id_regwrite;
         ex_memread_r  <= id_memread;
      end else begin
         ex_rs_r       <= '0;
         ex_rt_r       <= '0;
         ex_dest_r     <= '0;
         ex_regwrite_r <= 1'b0;
         ex_memread_r  <= 1'b0;
      end
   end

   // EX/MEM and MEM/WB shadows advance every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_dest_r     <= '0;
         mem_regwrite_r <= 1'b0;
         wb_dest_r      <= '0;
         wb_regwrite_r  <= 1'b0;
      end else begin
         mem_dest_r     <= ex_dest_r;
         mem_regwrite_r <= ex_regwrite_r;
         wb_dest_r      <= mem_dest_r;
         wb_regwrite_r  <= mem_regwrite_r;
      end
   end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: directed scenarios plus randomized traffic
// checked against a model that keeps the history of instructions that entered EX.
module tb_fwd_hazard_unit;

   typedef struct packed {
      logic [4:0] rs;
      logic [4:0] rt;
      logic [4:0] dest;
      logic       rw;
      logic       mr;
   } instr_t;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic       id_valid = 1'b0;
   logic [4:0] id_rs = 5'd0;
   logic [4:0] id_rt = 5'd0;
   logic [4:0] id_dest = 5'd0;
   logic       id_regwrite = 1'b0;
   logic       id_memread = 1'b0;
   logic       flush = 1'b0;
   logic [1:0] fwd_a;
   logic [1:0] fwd_b;
   logic       stall;

   int total = 0;
   int bad = 0;

   instr_t     hist[$];   // [2]=in EX, [1]=in MEM, [0]=in WB
   logic [1:0] ea;
   logic [1:0] eb;
   logic       es;

   fwd_hazard_unit #(.REGW(5), .NREG_ZERO(0)) dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_dest(id_dest), .id_regwrite(id_regwrite), .id_memread(id_memread),
      .flush(flush), .fwd_a(fwd_a), .fwd_b(fwd_b), .stall(stall)
   );

   always #5 clk = ~clk;

   function automatic logic [1:0] ref_sel(input logic [4:0] src);
      if (src == 5'd0) return 2'b00;
      if (hist[1].rw && hist[1].dest == src) return 2'b10;
      if (hist[0].rw && hist[0].dest == src) return 2'b01;
      return 2'b00;
   endfunction

   task automatic model_reset();
      hist.delete();
      repeat (3) hist.push_back('0);
   endtask

   task automatic predict();
      ea = ref_sel(hist[2].rs);
      eb = ref_sel(hist[2].rt);
      es = hist[2].mr && (hist[2].dest != 5'd0) && id_valid &&
           ((hist[2].dest == id_rs) || (hist[2].dest == id_rt));
   endtask

   task automatic issue(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] d, input logic rw, input logic mr, input logic fl);
      id_valid = v; id_rs = rs; id_rt = rt; id_dest = d;
      id_regwrite = rw; id_memread = mr; flush = fl;
      #1;
      predict();
   endtask

   task automatic nop();
      issue(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic tick();
      instr_t e;
      predict();
      @(posedge clk);
      if (id_valid && !es && !flush) e = '{id_rs, id_rt, id_dest, id_regwrite, id_memread};
      else e = '0;
      hist.push_back(e);
      void'(hist.pop_front());
      #1;
      predict();
   endtask

   task automatic drain();
      nop(); tick(); tick(); tick();
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      model_reset();
      for (int i = 0; i < 4; i++) begin
         issue(1'b1, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               1'b1, 1'($urandom_range(0, 1)), 1'b0);
         @(negedge clk);
         total++;
         if ({fwd_a, fwd_b, stall} !== 5'b0) begin
            bad++; $display("FAIL reset_hold: got %b want 00000", {fwd_a, fwd_b, stall});
         end
      end
      rst_n = 1'b1;
      nop(); tick();
      total++;
      if ({fwd_a, fwd_b, stall} !== 5'b0) begin
         bad++; $display("FAIL reset_release: got %b want 00000", {fwd_a, fwd_b, stall});
      end
   endtask

   task automatic test_exmem_fwd();
      drain();
      issue(1'b1, 5'd1, 5'd2, 5'd3, 1'b1, 1'b0, 1'b0); tick();
      issue(1'b1, 5'd3, 5'd4, 5'd8, 1'b1, 1'b0, 1'b0); tick();
      nop();
      total++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b00) begin
         bad++; $display("FAIL exmem_fwd: got a=%b b=%b want a=10 b=00", fwd_a, fwd_b);
      end
   endtask

   task automatic test_memwb_priority();
      drain();
      issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0); tick();
      issue(1'b1, 5'd1, 5'd2, 5'd12, 1'b1, 1'b0, 1'b0); tick();
      issue(1'b1, 5'd5, 5'd2, 5'd13, 1'b1, 1'b0, 1'b0); tick();
      nop();
      total++;
      if (fwd_a !== 2'b01 || fwd_b !== 2'b00) begin
         bad++; $display("FAIL memwb_fwd: got a=%b b=%b want a=01 b=00", fwd_a, fwd_b);
      end
      drain();
      issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0); tick();
      issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0); tick();
      issue(1'b1, 5'd5, 5'd5, 5'd14, 1'b1, 1'b0, 1'b0); tick();
      nop();
      total++;
      if (fwd_a !== 2'b10 || fwd_b !== 2'b10) begin
         bad++; $display("FAIL fwd_priority: got a=%b b=%b want a=10 b=10", fwd_a, fwd_b);
      end
   endtask

   task automatic test_load_use();
      drain();
      issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0); tick();
      issue(1'b1, 5'd7, 5'd2, 5'd15, 1'b1, 1'b0, 1'b0);
      total++;
      if (stall !== 1'b1) begin
         bad++; $display("FAIL load_use_stall: got %b want 1", stall);
      end
      tick();
      total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL load_use_one_cycle: got %b want 0", stall);
      end
      total++;
      if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
         bad++; $display("FAIL load_use_bubble: got a=%b b=%b want 00 00", fwd_a, fwd_b);
      end
      tick();
      nop();
      total++;
      if (fwd_a !== 2'b01) begin
         bad++; $display("FAIL load_use_fwd: got %b want 01", fwd_a);
      end
   endtask

   task automatic test_zero_and_nowrite();
      drain();
      issue(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b0, 1'b0); tick();
      issue(1'b1, 5'd0, 5'd0, 5'd16, 1'b1, 1'b0, 1'b0); tick();
      nop();
      total++;
      if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
         bad++; $display("FAIL zero_reg_fwd: got a=%b b=%b want 00 00", fwd_a, fwd_b);
      end
      drain();
      issue(1'b1, 5'd1, 5'd2, 5'd6, 1'b0, 1'b0, 1'b0); tick();
      issue(1'b1, 5'd6, 5'd2, 5'd17, 1'b1, 1'b0, 1'b0); tick();
      nop();
      total++;
      if (fwd_a !== 2'b00) begin
         bad++; $display("FAIL nowrite_fwd: got %b want 00", fwd_a);
      end
      drain();
      issue(1'b1, 5'd1, 5'd2, 5'd0, 1'b1, 1'b1, 1'b0); tick();
      issue(1'b1, 5'd0, 5'd0, 5'd18, 1'b1, 1'b0, 1'b0);
      total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL zero_reg_stall: got %b want 0", stall);
      end
      tick();
   endtask

   task automatic test_flush();
      drain();
      issue(1'b1, 5'd1, 5'd2, 5'd9, 1'b1, 1'b0, 1'b1); tick();
      issue(1'b1, 5'd9, 5'd9, 5'd19, 1'b1, 1'b0, 1'b0); tick();
      nop();
      total++;
      if (fwd_a !== 2'b00 || fwd_b !== 2'b00) begin
         bad++; $display("FAIL flush_squash: got a=%b b=%b want 00 00", fwd_a, fwd_b);
      end
   endtask

   task automatic test_async_reset();
      drain();
      issue(1'b1, 5'd1, 5'd2, 5'd5, 1'b1, 1'b0, 1'b0); tick();
      issue(1'b1, 5'd5, 5'd2, 5'd20, 1'b1, 1'b0, 1'b0); tick();
      nop();
      total++;
      if (fwd_a !== 2'b10) begin
         bad++; $display("FAIL pre_reset_fwd: got %b want 10", fwd_a);
      end
      #1 rst_n = 1'b0;
      #1;
      total++;
      if ({fwd_a, fwd_b, stall} !== 5'b0) begin
         bad++; $display("FAIL async_reset_fwd: got %b want 00000", {fwd_a, fwd_b, stall});
      end
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      @(posedge clk) #1;
      issue(1'b1, 5'd1, 5'd2, 5'd7, 1'b1, 1'b1, 1'b0); tick();
      issue(1'b1, 5'd7, 5'd2, 5'd21, 1'b1, 1'b0, 1'b0);
      total++;
      if (stall !== 1'b1) begin
         bad++; $display("FAIL pre_reset_stall: got %b want 1", stall);
      end
      #2 rst_n = 1'b0;
      #1;
      total++;
      if (stall !== 1'b0) begin
         bad++; $display("FAIL async_reset_stall: got %b want 0", stall);
      end
      @(negedge clk) rst_n = 1'b1;
      model_reset();
      @(posedge clk) #1;
      issue(1'b1, 5'd5, 5'd7, 5'd22, 1'b1, 1'b0, 1'b0); tick();
      nop();
      total++;
      if ({fwd_a, fwd_b, stall} !== 5'b0) begin
         bad++; $display("FAIL post_reset_first: got %b want 00000", {fwd_a, fwd_b, stall});
      end
   endtask

   task automatic test_random();
      logic [4:0] rs, rt, d;
      logic v, rw, mr, fl, held;
      held = 1'b0;
      rs = 5'd0; rt = 5'd0; d = 5'd0; v = 1'b0; rw = 1'b0; mr = 1'b0; fl = 1'b0;
      for (int i = 0; i < 400; i++) begin
         if (!held) begin
            rs = 5'($urandom_range(0, 7));
            rt = 5'($urandom_range(0, 7));
            d  = 5'($urandom_range(0, 7));
            v  = ($urandom_range(0, 99) < 85);
            rw = ($urandom_range(0, 99) < 75);
            mr = ($urandom_range(0, 99) < 30);
         end
         fl = ($urandom_range(0, 99) < 10);
         issue(v, rs, rt, d, rw, mr, fl);
         total++;
         if (fwd_a !== ea || fwd_b !== eb || stall !== es) begin
            bad++;
            $display("FAIL random[%0d]: got a=%b b=%b s=%b want a=%b b=%b s=%b",
                     i, fwd_a, fwd_b, stall, ea, eb, es);
         end
         held = es && !fl;
         tick();
      end
   endtask

   initial begin
      test_reset();
      test_exmem_fwd();
      test_memwb_priority();
      test_load_use();
      test_zero_and_nowrite();
      test_flush();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
